pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REG_WIDTH, 5, register-index width; MC_LATENCY, 4, execute-stage cycles of a multi-cycle op (legal range 1..16); CNT_WIDTH, $clog2(MC_LATENCY+1), derived.
REQ-002 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 rs1_d, rs2_d  in  REG_WIDTH  Decode source indices.
REQ-004 rs1_e, rs2_e, rd_e  in  REG_WIDTH  Execute source/destination indices.
REQ-005 result_src_e  in  2  Execute result select; RES_LOAD = 2'b01 marks a load.
REQ-006 mc_start_e  in  1  multi-cycle (mul/div) op in Execute.
REQ-007 pc_src_e  in  1  taken branch/jump resolved in Execute.
REQ-008 rd_m, rd_w  in  REG_WIDTH; reg_write_m, reg_write_w  in  1  Memory/Writeback destinations.
REQ-009 mem_req_m  in  1  load/store in Memory; mem_ready  in  1  data memory ready.
REQ-010 forward_a, forward_b  out  2  operand select: 00 regfile, 01 Writeback, 10 Memory.
REQ-011 stall_f, stall_d, stall_e, stall_m  out  1  hold stage register.
REQ-012 flush_d, flush_e, flush_m, flush_w  out  1  bubble stage register.
REQ-013 mc_busy  out  1  FSM in MC_BUSY; mc_done  out  1  one-cycle multi-cycle completion pulse.

Function
REQ-014 Forwarding SHALL be combinational per source: select 10 if rs==rd_m & reg_write_m & rs!=0, else 01 if rs==rd_w & reg_write_w & rs!=0, else 00; Memory has priority.
REQ-015 Load-use hazard SHALL be result_src_e==RES_LOAD & rd_e!=0 & (rs1_d==rd_e | rs2_d==rd_e); response: stall_f, stall_d, flush_e for exactly one cycle.
REQ-016 FSM states SHALL be IDLE, MC_BUSY, MEM_WAIT, tracking the memory stall source separately via return state.
REQ-017 IDLE & mc_start_e & MC_LATENCY>=2: assert stall_f, stall_d, stall_e, flush_m; load counter with MC_LATENCY-2; go MC_BUSY.
REQ-018 MC_BUSY: counter!=0 -> same stalls/flush_m, decrement; counter==0 -> no MC stall, mc_done=1, go IDLE; total MC stall = MC_LATENCY-1 cycles.
REQ-019 MC_LATENCY==1: mc_start_e SHALL cause no stall, no state change, mc_done=1 same cycle.
REQ-020 Memory stall (mem_req_m & !mem_ready), any state: assert stall_f, stall_d, stall_e, stall_m, flush_w; save state, go MEM_WAIT; counter frozen; suppress all other flushes.
REQ-021 MEM_WAIT: exit on mem_ready to the saved state, same cycle releasing stalls.
REQ-022 pc_src_e (no memory stall): flush_d, flush_e; stall_f, stall_d deasserted even if load-use is also true.
REQ-023 Priority SHALL be memory stall > multi-cycle stall > branch flush > load-use stall.
REQ-024 Load-use during MC stall SHALL be masked (covered by held stages).
REQ-025 mc_busy SHALL equal (state==MC_BUSY); counter SHALL never wrap below 0.

Reset
REQ-026 rst SHALL set state IDLE, counter 0, saved state IDLE at the next clk edge.
REQ-027 While rst high all stall/flush outputs, mc_busy, mc_done SHALL be 0 and forward_a/b 00.
REQ-028 rst mid-MC or mid-MEM_WAIT SHALL abandon the operation without an mc_done pulse.

Structure
REQ-029 Package hazard_pkg SHALL hold the state enum, forward-select enum (FWD_NONE, FWD_W, FWD_M) and RES_LOAD.
REQ-030 One sub-module fwd_sel (one source operand's forwarding compare) SHALL be instantiated twice.

Verification
REQ-031 rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a=10; rs1_e=0 same -> 00.
REQ-032 result_src_e=01, rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1 one cycle; rd_e=0 -> no stall.
REQ-033 MC_LATENCY=4, mc_start_e held -> stall_e high 3 cycles, mc_done on 4th, mc_busy cycles 2-4.
REQ-034 mem_ready low 2 cycles during MC_BUSY counter=1 -> all four stalls 2 cycles, counter held, then MC resumes, mc_done one cycle later.
REQ-035 pc_src_e=1 with load-use true -> flush_d=flush_e=1, stall_f=0; with memory stall -> flushes 0.
REQ-036 rst asserted in MC_BUSY -> next cycle state IDLE, outputs 0, no mc_done.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects, the load result encoding and the bundled stall/flush controls.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MC_BUSY  = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_e;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctrl_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one Execute source operand; the Memory stage wins
// over Writeback, and register 0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_WIDTH = 5
) (
  input  logic [REG_WIDTH-1:0] rs,
  input  logic [REG_WIDTH-1:0] rd_m,
  input  logic                 reg_write_m,
  input  logic [REG_WIDTH-1:0] rd_w,
  input  logic                 reg_write_w,
  output fwd_e                 fwd
);

  // NOTE: combinational blocks assign every output a default first so no
  // path through the if/else leaves a value held, which would infer a latch.
  always_comb begin
    fwd = FWD_NONE;
    if (rs != '0 && rs == rd_m && reg_write_m) begin
      fwd = FWD_M;
    end else if (rs != '0 && rs == rd_w && reg_write_w) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a five-stage pipeline: operand forwarding, load-use stall,
// multi-cycle execute stall, memory wait stall and branch flush.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_WIDTH  = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_WIDTH  = $clog2(MC_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] rs1_d,
  input  logic [REG_WIDTH-1:0] rs2_d,
  input  logic [REG_WIDTH-1:0] rs1_e,
  input  logic [REG_WIDTH-1:0] rs2_e,
  input  logic [REG_WIDTH-1:0] rd_e,
  input  logic [1:0]           result_src_e,
  input  logic                 mc_start_e,
  input  logic                 pc_src_e,
  input  logic [REG_WIDTH-1:0] rd_m,
  input  logic [REG_WIDTH-1:0] rd_w,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  input  logic                 mem_req_m,
  input  logic                 mem_ready,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_m,
  output logic                 flush_w,
  output logic                 mc_busy,
  output logic                 mc_done
);

  localparam bit MC_MULTI = (MC_LATENCY >= 2);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
    MC_MULTI ? CNT_WIDTH'(MC_LATENCY - 2) : '0;

  hz_state_e            state_q, state_d, ret_q, ret_d, eff_state;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  hz_ctrl_t             ctrl;
  logic                 mc_done_c;
  logic                 mc_stall;
  logic                 mem_hold;
  logic                 load_use;
  fwd_e                 fwd_a, fwd_b;

  fwd_sel #(.REG_WIDTH(REG_WIDTH)) u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_a)
  );

  fwd_sel #(.REG_WIDTH(REG_WIDTH)) u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_b)
  );

  assign load_use = (result_src_e == RES_LOAD) && (rd_e != '0) &&
                    ((rs1_d == rd_e) || (rs2_d == rd_e));

  // Once in MEM_WAIT only mem_ready releases the hold; the cycle it does,
  // the interrupted state's logic runs so no multi-cycle step is lost.
  assign mem_hold  = (state_q == MEM_WAIT) ? !mem_ready : (mem_req_m && !mem_ready);
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    ctrl      = '0;
    mc_done_c = 1'b0;
    mc_stall  = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    ret_d     = ret_q;

    if (mem_hold) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
      if (state_q != MEM_WAIT) begin
        ret_d   = state_q;
        state_d = MEM_WAIT;
      end
    end else begin
      state_d = eff_state;
      unique case (eff_state)
        MC_BUSY: begin
          if (cnt_q != '0) begin
            mc_stall = 1'b1;
            cnt_d    = cnt_q - CNT_WIDTH'(1);
          end else begin
            mc_done_c = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          if (mc_start_e) begin
            if (MC_MULTI) begin
              mc_stall = 1'b1;
              cnt_d    = CNT_LOAD;
              state_d  = MC_BUSY;
            end else begin
              mc_done_c = 1'b1;
            end
          end
        end
      endcase

      // Held Decode/Execute already cover a load-use pair, and a branch
      // cannot resolve while Execute is stalled.
      if (mc_stall) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.flush_m = 1'b1;
      end else if (pc_src_e) begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end else if (load_use) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ret_q   <= IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  assign forward_a = rst ? FWD_NONE : fwd_a;
  assign forward_b = rst ? FWD_NONE : fwd_b;
  assign stall_f   = ctrl.stall_f & ~rst;
  assign stall_d   = ctrl.stall_d & ~rst;
  assign stall_e   = ctrl.stall_e & ~rst;
  assign stall_m   = ctrl.stall_m & ~rst;
  assign flush_d   = ctrl.flush_d & ~rst;
  assign flush_e   = ctrl.flush_e & ~rst;
  assign flush_m   = ctrl.flush_m & ~rst;
  assign flush_w   = ctrl.flush_w & ~rst;
  assign mc_busy   = (state_q == MC_BUSY) & ~rst;
  assign mc_done   = mc_done_c & ~rst;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MC_LATENCY = 4): single-cycle
// vectors from a reset IDLE state, then cycle-by-cycle multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic       mc_start_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready;
  logic [1:0] forward_a, forward_b;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic       mc_busy, mc_done;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [1:0]  result_src_e;
    logic        mc_start_e, pc_src_e;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w, mem_req_m, mem_ready;
    logic [13:0] exp;
  } vec_t;

  pipeline_hazard_ctrl #(.REG_WIDTH(5), .MC_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .result_src_e(result_src_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .mc_busy(mc_busy), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output word: {fwd_a, fwd_b, stall f/d/e/m, flush d/e/m/w, busy, done}
  function automatic logic [13:0] ex(int fa, int fb, int st, int fl, int busy, int done);
    return {2'(fa), 2'(fb), 4'(st), 4'(fl), 1'(busy), 1'(done)};
  endfunction

  function automatic vec_t mkv(int r, int r1d, int r2d, int r1e, int r2e, int rde, int rsrc,
                               int mcs, int pcs, int rdm, int rdw, int wm, int ww,
                               int mreq, int mrdy, logic [13:0] e);
    vec_t t;
    t.rst = 1'(r);           t.rs1_d = 5'(r1d);      t.rs2_d = 5'(r2d);
    t.rs1_e = 5'(r1e);       t.rs2_e = 5'(r2e);      t.rd_e = 5'(rde);
    t.result_src_e = 2'(rsrc);
    t.mc_start_e = 1'(mcs);  t.pc_src_e = 1'(pcs);
    t.rd_m = 5'(rdm);        t.rd_w = 5'(rdw);
    t.reg_write_m = 1'(wm);  t.reg_write_w = 1'(ww);
    t.mem_req_m = 1'(mreq);  t.mem_ready = 1'(mrdy);
    t.exp = e;
    return t;
  endfunction

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (fa fb stFDEM flDEMW busy done)", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t t, input string nm);
    @(negedge clk);
    rst = t.rst;
    rs1_d = t.rs1_d; rs2_d = t.rs2_d; rs1_e = t.rs1_e; rs2_e = t.rs2_e; rd_e = t.rd_e;
    result_src_e = t.result_src_e; mc_start_e = t.mc_start_e; pc_src_e = t.pc_src_e;
    rd_m = t.rd_m; rd_w = t.rd_w; reg_write_m = t.reg_write_m; reg_write_w = t.reg_write_w;
    mem_req_m = t.mem_req_m; mem_ready = t.mem_ready;
    #1;
    check(nm, {forward_a, forward_b, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w, mc_busy, mc_done}, t.exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; result_src_e = '0;
    mc_start_e = 1'b0; pc_src_e = 1'b0; rd_m = '0; rd_w = '0;
    reg_write_m = 1'b0; reg_write_w = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_seq(input vec_t rows[$], input string nm);
    do_reset();
    foreach (rows[i]) apply_vec(rows[i], $sformatf("%s_c%0d", nm, i + 1));
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    //             rst r1d r2d r1e r2e rde src mcs pcs rdm rdw wm ww mrq mrd  expected
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 5, 0, 0, 0, 0, 0, 5, 5, 1, 1, 0, 1, ex(2, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 1, 1, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 7, 9, 0, 0, 0, 0, 9, 7, 1, 1, 0, 1, ex(1, 2, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 7, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 0, 4, 0, 0, 0, 0, 4, 4, 0, 1, 0, 1, ex(0, 1, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1100, 'b0100, 0, 0)));
    tbl.push_back(mkv(0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 3, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 6, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1100, 'b0100, 0, 0)));
    tbl.push_back(mkv(0, 0, 3, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b1100, 0, 0)));
    tbl.push_back(mkv(0, 0, 3, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 1, 0, ex(0, 0, 'b1111, 'b0001, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(1, 0, 3, 5, 5, 3, 1, 1, 1, 5, 5, 1, 1, 1, 0, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 0, 0)));
    tbl.push_back(mkv(0, 0, 3, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 'b1111, 'b0001, 0, 0)));

    foreach (tbl[i]) begin
      do_reset();
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Multi-cycle op held in Execute; load-use inputs in cycles 2-3 stay masked.
    seq = {};
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 0, 0)));
    seq.push_back(mkv(0, 3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 1, 0)));
    seq.push_back(mkv(0, 3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 1, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 1, 1)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    run_seq(seq, "mc_run");

    // Memory wait while the counter sits at 1; a branch during the wait is suppressed.
    seq = {};
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 0, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 1, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 'b1111, 'b0001, 1, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, ex(0, 0, 'b1111, 'b0001, 0, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 'b1110, 'b0010, 0, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 1, 1)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    run_seq(seq, "mc_mem");

    // Reset in the middle of a multi-cycle op: no completion pulse afterwards.
    seq = {};
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b1110, 'b0010, 0, 0)));
    seq.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    run_seq(seq, "mc_rst");

    // Memory wait from IDLE, released into a load-use stall.
    seq = {};
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 'b1111, 'b0001, 0, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 'b1111, 'b0001, 0, 0)));
    seq.push_back(mkv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 'b1100, 'b0100, 0, 0)));
    seq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 'b0000, 'b0000, 0, 0)));
    run_seq(seq, "mem_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
